// File: rtl/uart_tx_fifo.sv
// UART transmitter with a transmit FIFO and a valid/ready input handshake.
// Runs on the system clock; bit timing comes from an internal baud counter.
//   clk, rst_n          : system clock, asynchronous active-low reset
//   in_data/in_valid    : word to queue, accepted when in_ready is high
//   in_ready            : FIFO not full
//   tx                  : serial line, idle high, registered
//   busy                : frame in progress or FIFO non-empty
//   fifo_count          : current FIFO occupancy
module uart_tx_fifo #(
  parameter int CLK_FREQ_HZ = 12000000,
  parameter int BAUD        = 9600,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [DATA_BITS-1:0]              in_data,
  input  logic                              in_valid,
  output logic                              in_ready,
  output logic                              tx,
  output logic                              busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);

  localparam int unsigned DIV   = CLK_FREQ_HZ / BAUD;
  localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned CW    = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e               state_q, state_d;
  logic [DIV_W-1:0]     baud_q, baud_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [DATA_BITS-1:0] head;
  logic                 push;
  logic                 pop;
  logic                 tick;

  assign in_ready   = (count_q != CW'(FIFO_DEPTH));
  assign busy       = (state_q != S_IDLE) || (count_q != '0);
  assign tx         = tx_q;
  assign fifo_count = count_q;

  assign push = in_valid && in_ready;
  assign head = mem[rd_ptr_q];
  assign tick = (baud_q == DIV_W'(DIV - 1));

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= in_data;
    end
  end

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    par_d    = par_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    pop      = 1'b0;

    if (state_q != S_IDLE) begin
      baud_d = tick ? '0 : baud_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        pop = (count_q != '0);
      end
      S_START: begin
        if (tick) begin
          state_d = S_DATA;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (bit_q == 4'(DATA_BITS - 1)) begin
            bit_d   = '0;
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (tick) begin
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (tick) begin
          if (bit_q == 4'(STOP_BITS - 1)) begin
            // Chain straight into the next frame when more data is queued.
            if (count_q != '0) begin
              pop = 1'b1;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (pop) begin
      shift_d  = head;
      par_d    = (^head) ^ (PARITY == 1);
      state_d  = S_START;
      baud_d   = '0;
      bit_d    = '0;
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // tx is registered from the current state, so the line trails the FSM
    // by one cycle; every bit still lasts exactly DIV cycles.
    case (state_q)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_q[0];
      S_PARITY: tx_d = par_q;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      tx_q     <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      tx_q     <= tx_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

  localparam int NCFG = 4;
  localparam int CF_CLK  [NCFG] = '{8, 15, 8, 10};
  localparam int CF_BAUD [NCFG] = '{1, 2, 1, 3};
  localparam int CF_DB   [NCFG] = '{8, 9, 8, 5};
  localparam int CF_PAR  [NCFG] = '{2, 1, 0, 1};
  localparam int CF_SB   [NCFG] = '{2, 1, 1, 2};
  localparam int CF_DEP  [NCFG] = '{4, 8, 2, 8};

  logic clk = 1'b0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   done_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Line-level picture of one frame: bit i is what the line carries during bit period i.
  function automatic longint model_frame(input longint d, input int db, input int par, input int sb);
    longint f = 0;
    int     pos = 1;
    int     ones = 0;
    for (int i = 0; i < db; i++) begin
      f = f | (((d >> i) & 64'd1) << pos);
      ones += int'((d >> i) & 64'd1);
      pos++;
    end
    if (par != 0) begin
      f = f | (longint'((par == 2) ? (ones % 2) : (1 - ones % 2)) << pos);
      pos++;
    end
    for (int i = 0; i < sb; i++) begin
      f = f | (64'd1 << pos);
      pos++;
    end
    return f;
  endfunction

  for (genvar g = 0; g < NCFG; g++) begin : gcfg
    localparam int DIV   = CF_CLK[g] / CF_BAUD[g];
    localparam int DB    = CF_DB[g];
    localparam int PAR   = CF_PAR[g];
    localparam int SB    = CF_SB[g];
    localparam int DEP   = CF_DEP[g];
    localparam int NB    = 1 + DB + ((PAR != 0) ? 1 : 0) + SB;
    localparam int FRAME = NB * DIV;
    localparam int CW    = $clog2(DEP + 1);

    logic          rst_n;
    logic [DB-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic          tx;
    logic          busy;
    logic [CW-1:0] fifo_count;

    logic [DB-1:0] exp_q [$];
    int            starts_q [$];

    uart_tx_fifo #(
      .CLK_FREQ_HZ(CF_CLK[g]),
      .BAUD(CF_BAUD[g]),
      .DATA_BITS(DB),
      .PARITY(PAR),
      .STOP_BITS(SB),
      .FIFO_DEPTH(DEP)
    ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .in_data(in_data),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .tx(tx),
      .busy(busy),
      .fifo_count(fifo_count)
    );

    // Monitor: decodes frames from the line and scores them against the queue.
    initial begin : mon
      bit            active;
      bit            stable;
      int            b;
      int            k;
      logic [15:0]   obs;
      logic [DB-1:0] w;
      active = 1'b0;
      stable = 1'b1;
      b = 0;
      k = 0;
      obs = '0;
      w = '0;
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          active = 1'b0;
        end else begin
          if (!active && tx === 1'b0) begin
            starts_q.push_back(cyc);
            check_eq($sformatf("cfg%0d_start_has_expected_word", g), longint'(exp_q.size() != 0), 1);
            w = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
            active = 1'b1;
            stable = 1'b1;
            b = 0;
            k = 0;
            obs = '0;
          end
          if (active) begin
            if (k == 0) obs[b] = tx;
            else if (tx !== obs[b]) stable = 1'b0;
            k++;
            if (k == DIV) begin
              k = 0;
              b++;
              if (b == NB) begin
                active = 1'b0;
                check_eq($sformatf("cfg%0d_frame_bits", g), longint'(obs), model_frame(longint'(w), DB, PAR, SB));
                check_eq($sformatf("cfg%0d_bit_period_stable", g), longint'(stable), 1);
              end
            end
          end
        end
      end
    end

    task automatic push_word(input logic [DB-1:0] d, output int pcyc);
      bit acc = 1'b0;
      pcyc = -1;
      in_data = d;
      in_valid = 1'b1;
      for (int t = 0; t < (DEP + 2) * FRAME + 10; t++) begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk);
        #1;
        if (acc) begin
          exp_q.push_back(d);
          pcyc = cyc;
          break;
        end
      end
      check_eq($sformatf("cfg%0d_push_accepted", g), longint'(pcyc >= 0), 1);
    endtask

    task automatic drain(input int bound);
      int t = 0;
      in_valid = 1'b0;
      while ((busy || exp_q.size() != 0) && t < bound) begin
        @(posedge clk);
        #1;
        t++;
      end
      repeat (3) begin
        @(posedge clk);
        #1;
      end
      check_eq($sformatf("cfg%0d_drained_queue", g), exp_q.size(), 0);
      check_eq($sformatf("cfg%0d_drained_busy", g), busy, 0);
    endtask

    initial begin : stim
      int            pc;
      int            pc2;
      int            drop;
      int            n0;
      int            t;
      int            bad;
      logic [DB-1:0] w;
      rst_n = 1'b0;
      in_valid = 1'b0;
      in_data = '0;
      repeat (3) @(posedge clk);
      #1;
      check_eq($sformatf("cfg%0d_rst_tx", g), tx, 1);
      check_eq($sformatf("cfg%0d_rst_busy", g), busy, 0);
      check_eq($sformatf("cfg%0d_rst_count", g), fifo_count, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_eq($sformatf("cfg%0d_post_rst_ready", g), in_ready, 1);
      check_eq($sformatf("cfg%0d_post_rst_tx", g), tx, 1);

      // Single word: start-bit latency and busy release.
      n0 = starts_q.size();
      w = DB'(8'h4B);
      push_word(w, pc);
      in_valid = 1'b0;
      drop = -1;
      for (int i = 0; i < FRAME + 20; i++) begin
        @(posedge clk);
        #1;
        if (!busy) begin
          drop = cyc;
          break;
        end
      end
      check_eq($sformatf("cfg%0d_start_latency", g), (starts_q.size() > n0) ? starts_q[n0] : -1, pc + 2);
      check_eq($sformatf("cfg%0d_busy_drop", g), drop, pc + 1 + FRAME);
      drain(4 * FRAME);

      // Two words back-to-back: no gap between frames.
      n0 = starts_q.size();
      w = '0;
      push_word(w, pc);
      w = '1;
      push_word(w, pc2);
      check_eq($sformatf("cfg%0d_second_push_next_cycle", g), pc2 - pc, 1);
      drain(4 * FRAME);
      check_eq($sformatf("cfg%0d_frame_pitch", g),
               (starts_q.size() > n0 + 1) ? starts_q[n0 + 1] - starts_q[n0] : -1, FRAME);

      // Burst into an idle transmitter until full.
      pc2 = 0;
      for (int i = 0; i < DEP + 1; i++) begin
        w = DB'($urandom);
        push_word(w, pc);
        if (i == 0) pc2 = pc;
      end
      check_eq($sformatf("cfg%0d_burst_accept_span", g), pc - pc2, DEP);
      @(negedge clk);
      check_eq($sformatf("cfg%0d_full_count", g), fifo_count, DEP);
      check_eq($sformatf("cfg%0d_full_ready", g), in_ready, 0);
      @(posedge clk);
      #1;
      w = DB'($urandom);
      push_word(w, pc);
      check_eq($sformatf("cfg%0d_held_off_until_pop", g), pc - pc2, FRAME + 2);
      drain((DEP + 4) * FRAME);

      // Random traffic.
      for (int i = 0; i < 20; i++) begin
        in_valid = 1'b0;
        t = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, FRAME)) : int'($urandom_range(0, 2));
        repeat (t) begin
          @(posedge clk);
          #1;
        end
        w = DB'($urandom);
        push_word(w, pc);
      end
      drain(30 * FRAME);

      // Reset in the data bits of the second of three queued frames.
      n0 = starts_q.size();
      for (int i = 0; i < 3; i++) begin
        w = DB'($urandom);
        push_word(w, pc);
      end
      in_valid = 1'b0;
      t = 0;
      while (starts_q.size() < n0 + 2 && t < 3 * FRAME) begin
        @(posedge clk);
        #1;
        t++;
      end
      check_eq($sformatf("cfg%0d_second_frame_started", g), longint'(starts_q.size() >= n0 + 2), 1);
      repeat (2 * DIV) begin
        @(posedge clk);
        #1;
      end
      rst_n = 1'b0;
      #1;
      check_eq($sformatf("cfg%0d_midframe_rst_tx", g), tx, 1);
      check_eq($sformatf("cfg%0d_midframe_rst_count", g), fifo_count, 0);
      check_eq($sformatf("cfg%0d_midframe_rst_busy", g), busy, 0);
      exp_q.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      bad = 0;
      for (int i = 0; i < 2 * FRAME; i++) begin
        @(negedge clk);
        if (tx !== 1'b1 || busy !== 1'b0) bad++;
      end
      check_eq($sformatf("cfg%0d_quiet_after_reset", g), bad, 0);
      check_eq($sformatf("cfg%0d_ready_after_reset", g), in_ready, 1);
      done_cnt++;
    end
  end

  // Default parameters: 12 MHz / 9600 baud, 8N1, one 0x55 frame.
  logic       d_rst_n;
  logic [7:0] d_in_data;
  logic       d_in_valid;
  logic       d_in_ready;
  logic       d_tx;
  logic       d_busy;
  logic [4:0] d_fifo_count;

  uart_tx_fifo ud (
    .clk(clk),
    .rst_n(d_rst_n),
    .in_data(d_in_data),
    .in_valid(d_in_valid),
    .in_ready(d_in_ready),
    .tx(d_tx),
    .busy(d_busy),
    .fifo_count(d_fifo_count)
  );

  initial begin : dflt
    int   pc;
    int   drop;
    int   tr [$];
    logic prev;
    bit   acc;
    pc = -1;
    drop = -1;
    d_rst_n = 1'b0;
    d_in_valid = 1'b0;
    d_in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    d_rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("dflt_rst_tx", d_tx, 1);
    check_eq("dflt_rst_count", d_fifo_count, 0);
    d_in_data = 8'h55;
    d_in_valid = 1'b1;
    for (int t = 0; t < 10 && pc < 0; t++) begin
      @(negedge clk);
      acc = d_in_ready;
      @(posedge clk);
      #1;
      if (acc) pc = cyc;
    end
    d_in_valid = 1'b0;
    check_eq("dflt_push_accepted", longint'(pc >= 0), 1);
    prev = 1'b1;
    for (int t = 0; t < 12600; t++) begin
      @(negedge clk);
      if (d_tx !== prev) begin
        tr.push_back(cyc);
        prev = d_tx;
      end
      if (!d_busy && drop < 0) drop = cyc;
    end
    check_eq("dflt_transitions", tr.size(), 10);
    check_eq("dflt_start_latency", (tr.size() > 0) ? tr[0] : -1, pc + 2);
    for (int i = 1; i < 10; i++) begin
      check_eq($sformatf("dflt_bit%0d_length", i - 1), (tr.size() > i) ? tr[i] - tr[i - 1] : -1, 1250);
    end
    check_eq("dflt_frame_busy_drop", drop, pc + 1 + 12500);
    check_eq("dflt_final_tx", d_tx, 1);
    done_cnt++;
  end

  initial begin : fin
    int t;
    t = 0;
    while (done_cnt < NCFG + 1 && t < 60000) begin
      @(posedge clk);
      t++;
    end
    check_eq("all_sequences_finished", done_cnt, NCFG + 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
